multiplier_round_robin_arbiter: RTL and testbench

//  Shares one sequential signed multiplier (valid_entry/busy/data_valid handshake) among REQUESTERS

---
 rtl/multiplier_round_robin_arbiter.sv | 126 ++++++++++++
 tb/tb_multiplier_round_robin_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_round_robin_arbiter.sv
// Round-robin front end that shares one sequential signed multiplier among REQUESTERS clients.
// One operation in flight; the product is routed back to the granted client as a one-hot pulse.
module multiplier_round_robin_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int REQUESTERS = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_n_i,
   input  logic                           clk_en_i,
   input  logic [REQUESTERS-1:0]          req_valid_i,
   input  logic [REQUESTERS*DATA_WIDTH-1:0] req_operand_A_i,
   input  logic [REQUESTERS*DATA_WIDTH-1:0] req_operand_B_i,
   output logic [REQUESTERS-1:0]          req_ready_o,
   output logic [2*DATA_WIDTH-1:0]        resp_result_o,
   output logic [REQUESTERS-1:0]          resp_valid_o,
   output logic [DATA_WIDTH-1:0]          mul_operand_A_o,
   output logic [DATA_WIDTH-1:0]          mul_operand_B_o,
   output logic                           mul_valid_entry_o,
   output logic                           mul_clk_en_o,
   input  logic [2*DATA_WIDTH-1:0]        mul_result_i,
   input  logic                           mul_data_valid_i,
   input  logic                           mul_busy_i,
   output logic                           busy_o
);
   localparam int IDX_BITS = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [1:0]              state_q, state_d;
   logic [IDX_BITS-1:0]     ptr_q, ptr_d;
   logic [IDX_BITS-1:0]     gnt_q, gnt_d;
   logic [DATA_WIDTH-1:0]   opa_q, opa_d;
   logic [DATA_WIDTH-1:0]   opb_q, opb_d;
   logic [2*DATA_WIDTH-1:0] res_q, res_d;
   logic [REQUESTERS-1:0]   rvld_q, rvld_d;

   logic                    pick_vld;
   logic [IDX_BITS-1:0]     pick_idx;
   logic                    accept;

   // First valid client scanning from the pointer, wrapping modulo REQUESTERS.
   always_comb begin : rr_pick
      int j;
      j        = 0;
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int i = 0; i < REQUESTERS; i++) begin
         j = (int'(ptr_q) + i) % REQUESTERS;
         if (!pick_vld && req_valid_i[j]) begin
            pick_vld = 1'b1;
            pick_idx = IDX_BITS'(j);
         end
      end
   end

   assign accept = (state_q == S_IDLE) && clk_en_i && pick_vld;

   always_comb begin
      req_ready_o = '0;
      if (accept) req_ready_o[pick_idx] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      rvld_d  = '0;
      case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               gnt_d   = pick_idx;
               opa_d   = req_operand_A_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
               opb_d   = req_operand_B_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!mul_busy_i) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mul_data_valid_i) begin
               res_d         = mul_result_i;
               rvld_d[gnt_q] = 1'b1;
               ptr_d         = (gnt_q == IDX_BITS'(REQUESTERS-1)) ? '0 : gnt_q + IDX_BITS'(1);
               state_d       = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // clk_en_i low freezes everything, including a pending response pulse.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         rvld_q  <= '0;
      end else if (clk_en_i) begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         rvld_q  <= rvld_d;
      end
   end

   assign mul_operand_A_o   = opa_q;
   assign mul_operand_B_o   = opb_q;
   assign mul_valid_entry_o = (state_q == S_ISSUE) && !mul_busy_i && clk_en_i;
   assign mul_clk_en_o      = clk_en_i;
   assign resp_result_o     = res_q;
   assign resp_valid_o      = rvld_q;
   assign busy_o            = (state_q != S_IDLE);

endmodule

// File: tb/tb_multiplier_round_robin_arbiter.sv
// Bench for multiplier_round_robin_arbiter (DW=8, 4 clients) with a 5-cycle sequential multiplier
// model; accepted requests are queued with their expected product and matched against responses.
module tb_multiplier_round_robin_arbiter;
   localparam int DW = 8;
   localparam int NR = 4;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                clk_en = 1'b1;
   logic [NR-1:0]       req_valid = '0;
   logic [NR-1:0][DW-1:0] req_a = '0;
   logic [NR-1:0][DW-1:0] req_b = '0;
   logic [NR-1:0]       req_ready_o;
   logic [2*DW-1:0]     resp_result_o;
   logic [NR-1:0]       resp_valid_o;
   logic [DW-1:0]       mul_operand_A_o, mul_operand_B_o;
   logic                mul_valid_entry_o, mul_clk_en_o, busy_o;
   logic signed [2*DW-1:0] mul_res = '0;
   logic                mul_dv = 1'b0;
   logic                force_busy = 1'b0;
   logic                mul_busy;

   multiplier_round_robin_arbiter #(.DATA_WIDTH(DW), .REQUESTERS(NR)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en),
      .req_valid_i(req_valid), .req_operand_A_i(req_a), .req_operand_B_i(req_b),
      .req_ready_o(req_ready_o), .resp_result_o(resp_result_o), .resp_valid_o(resp_valid_o),
      .mul_operand_A_o(mul_operand_A_o), .mul_operand_B_o(mul_operand_B_o),
      .mul_valid_entry_o(mul_valid_entry_o), .mul_clk_en_o(mul_clk_en_o),
      .mul_result_i(mul_res), .mul_data_valid_i(mul_dv), .mul_busy_i(mul_busy),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   // Sequential multiplier model: completion pulse 5 cycles after the issue cycle.
   logic signed [DW-1:0] ma = '0, mb = '0;
   int                   mcnt = 0;
   assign mul_busy = (mcnt != 0) || force_busy;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcnt <= 0; mul_dv <= 1'b0; mul_res <= '0;
      end else if (clk_en) begin
         mul_dv <= 1'b0;
         if (mul_valid_entry_o) begin
            mcnt <= 4; ma <= mul_operand_A_o; mb <= mul_operand_B_o;
         end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin mul_dv <= 1'b1; mul_res <= ma * mb; end
         end
      end
   end

   int n_chk = 0;
   int n_fail = 0;
   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int k; logic [2*DW-1:0] p; int t0; } exp_t;
   exp_t q[$];
   int   grants[$];
   int   tb_ptr = 0;
   int   exp_extra = 0;
   int   acc_n[NR];
   int   acc_d[NR];
   int   post_n[NR];
   int   post_d[NR];
   bit   reissue[NR];
   logic [DW-1:0] pa[NR];
   logic [DW-1:0] pb[NR];

   initial for (int k = 0; k < NR; k++) begin
      acc_n[k] = 0; acc_d[k] = 0; post_n[k] = 0; post_d[k] = 0;
      reissue[k] = 1'b0; pa[k] = '0; pb[k] = '0;
   end

   // Monitor: retire responses first, then check/queue the grant offered in the same cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         tb_ptr = 0;
      end else begin
         exp_t e;
         int   pick;
         logic signed [2*DW-1:0] p;
         chk("mul_clk_en", 64'(mul_clk_en_o), 64'(clk_en));
         if (clk_en && resp_valid_o != '0) begin
            if (q.size() == 0) chk("resp_unexpected", 64'(resp_valid_o), 64'd0);
            else begin
               e = q.pop_front();
               chk("resp_owner", 64'(resp_valid_o), 64'd1 << e.k);
               chk("resp_result", 64'(resp_result_o), 64'(e.p));
               chk("resp_latency", 64'(cyc - e.t0), 64'(7 + exp_extra));
               tb_ptr = (e.k + 1) % NR;
            end
         end
         if (req_ready_o != '0) begin
            pick = -1;
            for (int i = 0; i < NR; i++)
               if (pick < 0 && req_valid[(tb_ptr + i) % NR]) pick = (tb_ptr + i) % NR;
            if (pick < 0) chk("ready_no_valid", 64'(req_ready_o), 64'd0);
            else begin
               chk("grant", 64'(req_ready_o), 64'd1 << pick);
               chk("one_in_flight", 64'(q.size()), 64'd0);
               p = $signed({{DW{req_a[pick][DW-1]}}, req_a[pick]})
                 * $signed({{DW{req_b[pick][DW-1]}}, req_b[pick]});
               e.k = pick; e.p = p; e.t0 = cyc;
               q.push_back(e);
               grants.push_back(pick);
               acc_n[pick]++;
            end
         end
      end
   end

   // Request driver: posts new requests and drops (or renews) them once accepted.
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < NR; k++) begin
         if (acc_n[k] != acc_d[k]) begin
            acc_d[k] = acc_n[k];
            if (reissue[k]) begin
               req_a[k] = DW'($urandom); req_b[k] = DW'($urandom);
            end else req_valid[k] = 1'b0;
         end
         if (post_n[k] != post_d[k]) begin
            post_d[k] = post_n[k];
            req_valid[k] = 1'b1; req_a[k] = pa[k]; req_b[k] = pb[k];
         end
      end
   end

   task automatic post_req(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
      pa[k] = a; pb[k] = b; post_n[k]++;
   endtask

   function automatic bit pending();
      bit r = 1'b0;
      for (int k = 0; k < NR; k++) if (post_n[k] != post_d[k]) r = 1'b1;
      return r;
   endfunction

   task automatic wait_quiet(input int maxc);
      int n = 0;
      do begin @(posedge clk); n++; end
      while ((q.size() != 0 || req_valid != '0 || pending() || busy_o) && n < maxc);
      if (n >= maxc) chk("quiet_timeout", 64'(q.size()), 64'd0);
      repeat (2) @(posedge clk);
   endtask

   task automatic wait_entry(input int maxc);
      int n = 0;
      do begin @(posedge clk); #1; n++; end while (!mul_valid_entry_o && n < maxc);
      if (!mul_valid_entry_o) chk("entry_timeout", 64'(mul_valid_entry_o), 64'd1);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int g0;
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int g0;
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 64'(req_ready_o), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_entry", 64'(mul_valid_entry_o), 64'd0);
      chk("rst_result", 64'(resp_result_o), 64'd0);
      chk("rst_mul_a", 64'(mul_operand_A_o), 64'd0);
      rst_n = 1'b1;

      // Single client, 3 * -5.
      g0 = grants.size();
      post_req(1, 8'd3, 8'hFB);
      wait_quiet(60);
      chk("t1_ngrants", 64'(grants.size() - g0), 64'd1);
      if (grants.size() > g0) chk("t1_gnt", 64'(grants[g0]), 64'd1);
      chk("t1_result", 64'(resp_result_o), 64'hFFF1);

      // All clients continuously valid from pointer 0.
      do_reset();
      g0 = grants.size();
      for (int k = 0; k < NR; k++) reissue[k] = 1'b1;
      for (int k = 0; k < NR; k++) post_req(k, DW'($urandom), DW'($urandom));
      n = 0;
      while (grants.size() < g0 + 5 && n < 200) begin @(posedge clk); n++; end
      for (int k = 0; k < NR; k++) reissue[k] = 1'b0;
      wait_quiet(200);
      chk("t2_ngrants", 64'(grants.size() >= g0 + 5), 64'd1);
      if (grants.size() >= g0 + 5)
         for (int i = 0; i < 5; i++) chk("t2_order", 64'(grants[g0+i]), 64'(i % NR));

      // Pointer moved to 3 by serving client 2; then clients 2 and 3 contend.
      do_reset();
      post_req(2, 8'h7F, 8'h80);
      wait_quiet(60);
      g0 = grants.size();
      post_req(2, 8'h11, 8'h22);
      post_req(3, 8'hF0, 8'h0F);
      wait_quiet(100);
      chk("t3_ngrants", 64'(grants.size() - g0), 64'd2);
      if (grants.size() >= g0 + 2) begin
         chk("t3_first", 64'(grants[g0]), 64'd3);
         chk("t3_second", 64'(grants[g0+1]), 64'd2);
      end

      // Multiplier busy for 3 cycles in ISSUE.
      exp_extra = 3;
      force_busy = 1'b1;
      post_req(0, 8'hF9, 8'h06);
      n = 0;
      do begin @(negedge clk); n++; end while (req_ready_o == '0 && n < 20);
      chk("t4_accept", 64'(req_ready_o), 64'b0001);
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         #1 chk("t4_hold", 64'(mul_valid_entry_o), 64'd0);
         chk("t4_busy", 64'(busy_o), 64'd1);
         @(posedge clk);
      end
      #1 force_busy = 1'b0;
      #1 chk("t4_issue", 64'(mul_valid_entry_o), 64'd1);
      chk("t4_opa", 64'(mul_operand_A_o), 64'hF9);
      chk("t4_opb", 64'(mul_operand_B_o), 64'h06);
      wait_quiet(60);
      exp_extra = 0;

      // Clock enable low 4 cycles during WAIT.
      exp_extra = 4;
      post_req(3, 8'h80, 8'h80);
      wait_entry(30);
      @(posedge clk);
      @(posedge clk);
      #1 clk_en = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1 chk("t5_frozen_busy", 64'(busy_o), 64'd1);
         chk("t5_no_resp", 64'(resp_valid_o), 64'd0);
      end
      clk_en = 1'b1;
      wait_quiet(60);
      exp_extra = 0;
      chk("t5_result", 64'(resp_result_o), 64'h4000);

      // Asynchronous reset in the middle of WAIT drops the operation.
      post_req(1, 8'h7F, 8'h7F);
      wait_entry(30);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_busy", 64'(busy_o), 64'd0);
      chk("t6_resp_valid", 64'(resp_valid_o), 64'd0);
      chk("t6_result", 64'(resp_result_o), 64'd0);
      chk("t6_mul_a", 64'(mul_operand_A_o), 64'd0);
      chk("t6_entry", 64'(mul_valid_entry_o), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      g0 = grants.size();
      post_req(2, 8'h80, 8'h7F);
      wait_quiet(60);
      chk("t6_ngrants", 64'(grants.size() - g0), 64'd1);
      if (grants.size() > g0) chk("t6_gnt", 64'(grants[g0]), 64'd2);
      chk("t6_after", 64'(resp_result_o), 64'hC080);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
